// File: rtl/tc_sram_pwr_pkg.sv
// Shared types and helpers for the SRAM bank power controller.
// The OFF state is only reachable when TC_SRAM_PWR_OFF_EN is defined.
package tc_sram_pwr_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        SLEEP  = 2'd1,
        OFF    = 2'd2,
        WAKE   = 2'd3
    } bank_pwr_state_e;

    // Width needed to hold the largest threshold or wake load value.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/tc_sram_bank_pwr_fsm.sv
// Per-bank power state machine with a shared idle/wake counter.
// Macro TC_SRAM_PWR_OFF_EN enables the SLEEP -> OFF timeout and powergate output.
module tc_sram_bank_pwr_fsm
    import tc_sram_pwr_pkg::*;
#(
    parameter int unsigned CntWidth        = 7,
    parameter int unsigned IdleSleepCycles = 16,
    parameter int unsigned IdleOffCycles   = 64,
    parameter int unsigned WakeSleepCycles = 2,
    parameter int unsigned WakeOffCycles   = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic bank_req,
    input  logic keep_on,
    output logic deepsleep,
    output logic powergate,
    output logic active
);

    localparam logic [CntWidth-1:0] SleepThr  = CntWidth'(IdleSleepCycles - 1);
    localparam logic [CntWidth-1:0] SleepLoad = CntWidth'(WakeSleepCycles);
    localparam logic [CntWidth-1:0] OffLoad   = CntWidth'(WakeOffCycles);
`ifdef TC_SRAM_PWR_OFF_EN
    localparam logic [CntWidth-1:0] OffThr    = CntWidth'(IdleOffCycles - 1);
`endif

    if (CntWidth < cnt_width(IdleSleepCycles, IdleOffCycles, WakeSleepCycles, WakeOffCycles))
    begin : g_bad_cnt
        $fatal(1, "tc_sram_bank_pwr_fsm: CntWidth too small");
    end

    bank_pwr_state_e     state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                wake;

    assign wake = bank_req | keep_on;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ACTIVE: begin
                if (wake) begin
                    cnt_d = '0;
                end else if (cnt_q == SleepThr) begin
                    state_d = SLEEP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SLEEP: begin
                if (wake) begin
                    state_d = WAKE;
                    cnt_d   = SleepLoad;
                end
`ifdef TC_SRAM_PWR_OFF_EN
                else if (cnt_q == OffThr) begin
                    state_d = OFF;
                    cnt_d   = '0;
                end
`endif
                else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OFF: begin
                if (wake) begin
                    state_d = WAKE;
                    cnt_d   = OffLoad;
                end
            end
            WAKE: begin
                // A load of N gives N cycles in WAKE; a load of 0 still gives one.
                if (cnt_q <= CntWidth'(1)) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ACTIVE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ACTIVE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deepsleep = (state_q == SLEEP);
    assign active    = (state_q == ACTIVE);
`ifdef TC_SRAM_PWR_OFF_EN
    assign powergate = (state_q == OFF);
`else
    assign powergate = 1'b0;
`endif

endmodule

// File: rtl/tc_sram_bank_pwr_ctrl.sv
// Power controller for a multibank SRAM: idle banks sleep, requests stall until woken.
// Macro TC_SRAM_PWR_OFF_EN enables the power-off state after a long sleep.
module tc_sram_bank_pwr_ctrl
    import tc_sram_pwr_pkg::*;
#(
    parameter int unsigned NumWords        = 1024,
    parameter int unsigned NumPorts        = 2,
    parameter int unsigned NumLogicBanks   = 4,
    parameter int unsigned Latency         = 1,
    parameter int unsigned IdleSleepCycles = 16,
    parameter int unsigned IdleOffCycles   = 64,
    parameter int unsigned WakeSleepCycles = 2,
    parameter int unsigned WakeOffCycles   = 8,
    parameter int unsigned AddrWidth       = (NumWords > 1) ? $clog2(NumWords) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumPorts-1:0]                 req_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
    output logic [NumPorts-1:0]                 gnt_o,
    output logic [NumPorts-1:0]                 sram_req_o,
    input  logic [NumLogicBanks-1:0]            keep_on_i,
    output logic [NumLogicBanks-1:0]            deepsleep_o,
    output logic [NumLogicBanks-1:0]            powergate_o,
    output logic [NumLogicBanks-1:0]            bank_active_o
);

    localparam int unsigned BankSelWidth = (NumLogicBanks > 1) ? $clog2(NumLogicBanks) : 1;
    localparam int unsigned CntWidth     =
        cnt_width(IdleSleepCycles, IdleOffCycles, WakeSleepCycles, WakeOffCycles);

    if (NumWords == 0 || (NumWords & (NumWords - 1)) != 0) begin : g_bad_words
        $fatal(1, "tc_sram_bank_pwr_ctrl: NumWords must be a power of two");
    end
    if (NumLogicBanks == 0 || (NumLogicBanks & (NumLogicBanks - 1)) != 0) begin : g_bad_banks
        $fatal(1, "tc_sram_bank_pwr_ctrl: NumLogicBanks must be a power of two");
    end
    if (AddrWidth != ((NumWords > 1) ? $clog2(NumWords) : 1)) begin : g_bad_aw
        $fatal(1, "tc_sram_bank_pwr_ctrl: AddrWidth must not be overridden");
    end
    if (NumLogicBanks > 1 && BankSelWidth > AddrWidth) begin : g_bad_sel
        $fatal(1, "tc_sram_bank_pwr_ctrl: more banks than words");
    end
    if (IdleSleepCycles <= Latency) begin : g_bad_idle
        $fatal(1, "tc_sram_bank_pwr_ctrl: IdleSleepCycles must exceed Latency");
    end
    if (IdleOffCycles < 1 || NumPorts < 1) begin : g_bad_misc
        $fatal(1, "tc_sram_bank_pwr_ctrl: IdleOffCycles and NumPorts must be >= 1");
    end

    logic [NumPorts-1:0][BankSelWidth-1:0] bank_sel;
    logic [NumLogicBanks-1:0]              bank_req;
    logic                                  unused_addr_bits;

    // Only the top address bits select a bank; the rest belong to the SRAM.
    assign unused_addr_bits = ^addr_i;

    if (NumLogicBanks > 1) begin : g_sel
        for (genvar p = 0; p < NumPorts; p++) begin : g_port
            assign bank_sel[p] = addr_i[p][AddrWidth-1 -: BankSelWidth];
        end
    end else begin : g_sel_single
        assign bank_sel = '0;
    end

    always_comb begin
        bank_req = '0;
        gnt_o    = '0;
        for (int b = 0; b < NumLogicBanks; b++) begin
            for (int p = 0; p < NumPorts; p++) begin
                if (req_i[p] && bank_sel[p] == BankSelWidth'(b)) begin
                    bank_req[b] = 1'b1;
                    gnt_o[p]    = bank_active_o[b];
                end
            end
        end
    end

    assign sram_req_o = gnt_o;

    for (genvar b = 0; b < NumLogicBanks; b++) begin : g_bank
        tc_sram_bank_pwr_fsm #(
            .CntWidth        (CntWidth),
            .IdleSleepCycles (IdleSleepCycles),
            .IdleOffCycles   (IdleOffCycles),
            .WakeSleepCycles (WakeSleepCycles),
            .WakeOffCycles   (WakeOffCycles)
        ) u_fsm (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .bank_req  (bank_req[b]),
            .keep_on   (keep_on_i[b]),
            .deepsleep (deepsleep_o[b]),
            .powergate (powergate_o[b]),
            .active    (bank_active_o[b])
        );
    end

endmodule

// File: tb/tb_tc_sram_bank_pwr_ctrl.sv
// Scoreboard bench for tc_sram_bank_pwr_ctrl: expected grant latencies are queued per port
// and checked by a monitor; bank power states are checked at fixed points.
module tb_tc_sram_bank_pwr_ctrl;

    localparam int NP = 2;
    localparam int NB = 4;
    localparam int AW = 10;
`ifdef TC_SRAM_PWR_OFF_EN
    localparam bit OffEn = 1'b1;
`else
    localparam bit OffEn = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_ni = 1'b0;
    logic [NP-1:0]          req_i = '0;
    logic [NP-1:0][AW-1:0]  addr_i = '0;
    logic [NB-1:0]          keep_on_i = '0;
    logic [NP-1:0]          gnt;
    logic [NP-1:0]          sram_req;
    logic [NB-1:0]          ds;
    logic [NB-1:0]          pg;
    logic [NB-1:0]          act;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q0[$];
    int exp_q1[$];
    int wait_cnt [NP];
    int exp_w;
    bit have;

    tc_sram_bank_pwr_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .addr_i        (addr_i),
        .gnt_o         (gnt),
        .sram_req_o    (sram_req),
        .keep_on_i     (keep_on_i),
        .deepsleep_o   (ds),
        .powergate_o   (pg),
        .bank_active_o (act)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, expv);
        end
    endtask

    task automatic check_pwr(input string name, input logic [NB-1:0] eds,
                             input logic [NB-1:0] epg, input logic [NB-1:0] eact);
        check({name, ".deepsleep"}, 32'(ds), 32'(eds));
        check({name, ".powergate"}, 32'(pg), 32'(epg));
        check({name, ".active"}, 32'(act), 32'(eact));
    endtask

    // Monitor: every grant pops the port's expected stall count.
    always @(negedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (gnt[p]) begin
                have = 1'b0;
                if (p == 0 && exp_q0.size() > 0) begin
                    exp_w = exp_q0.pop_front();
                    have  = 1'b1;
                end else if (p == 1 && exp_q1.size() > 0) begin
                    exp_w = exp_q1.pop_front();
                    have  = 1'b1;
                end
                check($sformatf("sram_req_p%0d", p), 32'(sram_req[p]), 32'd1);
                if (!have) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_grant_p%0d: got grant, expected none", p);
                end else begin
                    check($sformatf("grant_wait_p%0d", p), wait_cnt[p], exp_w);
                end
                wait_cnt[p] = 0;
            end else if (req_i[p]) begin
                wait_cnt[p]++;
            end
        end
    end

    task automatic push_exp(input int p, input int w);
        if (p == 0) exp_q0.push_back(w);
        else exp_q1.push_back(w);
    endtask

    task automatic issue(input int p, input logic [AW-1:0] a, input int exp_wait);
        logic got;
        push_exp(p, exp_wait);
        @(posedge clk); #2;
        req_i[p]  = 1'b1;
        addr_i[p] = a;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = gnt[p];
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL grant_timeout_p%0d: got no grant, expected one within 40 cycles", p);
        end
        @(posedge clk); #2;
        req_i[p] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_ni = 1'b0;
        @(negedge clk);
        check_pwr("reset", 4'b0000, 4'b0000, 4'b1111);
        @(posedge clk); #2;
        rst_ni = 1'b1;
    endtask

    initial begin
        do_reset();

        // Idle entry: active through idle cycle 16, asleep in cycle 17.
        repeat (15) @(posedge clk);
        @(negedge clk);
        check_pwr("idle_15", 4'b0000, 4'b0000, 4'b1111);
        @(posedge clk);
        @(negedge clk);
        check_pwr("idle_16", 4'b1111, 4'b0000, 4'b0000);

        // Wake bank 1 from SLEEP.
        issue(0, 10'h100, 3);
        @(negedge clk);
        check_pwr("wake_sleep", 4'b1101, 4'b0000, 4'b0010);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_pwr("resleep", 4'b1111, 4'b0000, 4'b0000);

        // Reset in the middle of bank 1 waking; the held request is granted in reset.
        push_exp(0, 2);
        @(posedge clk); #2;
        req_i[0]  = 1'b1;
        addr_i[0] = 10'h100;
        @(negedge clk);
        @(negedge clk);
        check_pwr("mid_wake", 4'b1101, 4'b0000, 4'b0000);
        @(posedge clk); #2;
        rst_ni = 1'b0;
        @(negedge clk);
        check_pwr("reset_mid_wake", 4'b0000, 4'b0000, 4'b1111);
        check("gnt_in_reset", 32'(gnt), 32'b01);
        @(posedge clk); #2;
        req_i[0] = 1'b0;
        @(posedge clk); #2;
        rst_ni = 1'b1;
        issue(0, 10'h100, 0);

        // Threshold race on bank 2: request lands in idle cycle 16.
        do_reset();
        repeat (14) @(posedge clk);
        issue(1, 10'h2A5, 0);
        @(negedge clk);
        check_pwr("race", 4'b1011, 4'b0000, 4'b0100);
        repeat (15) @(posedge clk);
        @(negedge clk);
        check_pwr("race_hold", 4'b1011, 4'b0000, 4'b0100);
        @(posedge clk);
        @(negedge clk);
        check_pwr("race_sleep", 4'b1111, 4'b0000, 4'b0000);

        // Long idle: OFF after 64 cycles of SLEEP only when enabled.
        do_reset();
        repeat (79) @(posedge clk);
        @(negedge clk);
        check_pwr("sleep_79", 4'b1111, 4'b0000, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        check_pwr("off_80", OffEn ? 4'b0000 : 4'b1111, OffEn ? 4'b1111 : 4'b0000, 4'b0000);

        // keep_on holds bank 0; then wake bank 3 while the others stay down.
        do_reset();
        keep_on_i = 4'b0001;
        repeat (200) @(posedge clk);
        @(negedge clk);
        check_pwr("keep_on", OffEn ? 4'b0000 : 4'b1110, OffEn ? 4'b1110 : 4'b0000, 4'b0001);
        issue(1, 10'h3FF, OffEn ? 9 : 3);
        @(negedge clk);
        check_pwr("wake_b3", OffEn ? 4'b0000 : 4'b0110, OffEn ? 4'b0110 : 4'b0000, 4'b1001);
        keep_on_i = 4'b0000;

        @(negedge clk);
        check("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
        check("exp_q1_drained", 32'(exp_q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
